lfsr_gen: RTL and testbench

- Parametrised multi-lane LFSR pattern generator. Successor to the fixed-tap single LFSR.
- Width-generic XNOR taps come from a package table. NUM_CH independent lanes are seeded in parallel.
- Features: beat-count and stop-code termination, valid/ready backpressure, abort.
- Feeds systolic-array input/weight streams in BIST and random-stimulus modes.

---
 rtl/lfsr_pkg.sv | 110 +++++++++++
 rtl/lfsr_lane.sv | 53 +++++
 rtl/lfsr_gen.sv | 154 +++++++++++++++
 tb/tb_lfsr_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared types and the XNOR tap table for the lfsr_gen generator.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
package lfsr_pkg;

  // Controller states of the generator
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Range of lane widths the tap table covers
  localparam int c_min_bits = 3;
  localparam int c_max_bits = 64;

  // True when the tap table has an entry for width n
  function automatic bit bits_supported(input int n);
    return (n >= c_min_bits) && (n <= c_max_bits);
  endfunction

  // Mask with the single bit for 1-based tap position t
  function automatic logic [63:0] tb1(input int t);
    return 64'd1 << (t - 1);
  endfunction

  // Four-tap convenience form (1-based positions)
  function automatic logic [63:0] tb4(input int a, input int b, input int c, input int d);
    return tb1(a) | tb1(b) | tb1(c) | tb1(d);
  endfunction

  // Maximal-length XNOR tap mask for an n-bit left-shifting LFSR.
  // Positions follow the classic XAPP052 table (1-based), converted to
  // 0-based mask bits; e.g. n=4 gives bits {3,2}, n=49 gives bits {48,39}.
  function automatic logic [63:0] lfsr_taps(input int n);
    logic [63:0] m;
    case (n)
      3:  m = tb1(3)  | tb1(2);
      4:  m = tb1(4)  | tb1(3);
      5:  m = tb1(5)  | tb1(3);
      6:  m = tb1(6)  | tb1(5);
      7:  m = tb1(7)  | tb1(6);
      8:  m = tb4(8, 6, 5, 4);
      9:  m = tb1(9)  | tb1(5);
      10: m = tb1(10) | tb1(7);
      11: m = tb1(11) | tb1(9);
      12: m = tb4(12, 6, 4, 1);
      13: m = tb4(13, 4, 3, 1);
      14: m = tb4(14, 5, 3, 1);
      15: m = tb1(15) | tb1(14);
      16: m = tb4(16, 15, 13, 4);
      17: m = tb1(17) | tb1(14);
      18: m = tb1(18) | tb1(11);
      19: m = tb4(19, 6, 2, 1);
      20: m = tb1(20) | tb1(17);
      21: m = tb1(21) | tb1(19);
      22: m = tb1(22) | tb1(21);
      23: m = tb1(23) | tb1(18);
      24: m = tb4(24, 23, 22, 17);
      25: m = tb1(25) | tb1(22);
      26: m = tb4(26, 6, 2, 1);
      27: m = tb4(27, 5, 2, 1);
      28: m = tb1(28) | tb1(25);
      29: m = tb1(29) | tb1(27);
      30: m = tb4(30, 6, 4, 1);
      31: m = tb1(31) | tb1(28);
      32: m = tb4(32, 22, 2, 1);
      33: m = tb1(33) | tb1(20);
      34: m = tb4(34, 27, 2, 1);
      35: m = tb1(35) | tb1(33);
      36: m = tb1(36) | tb1(25);
      37: m = tb4(37, 5, 4, 3) | tb1(2) | tb1(1);
      38: m = tb4(38, 6, 5, 1);
      39: m = tb1(39) | tb1(35);
      40: m = tb4(40, 38, 21, 19);
      41: m = tb1(41) | tb1(38);
      42: m = tb4(42, 41, 20, 19);
      43: m = tb4(43, 42, 38, 37);
      44: m = tb4(44, 43, 18, 17);
      45: m = tb4(45, 44, 42, 41);
      46: m = tb4(46, 45, 26, 25);
      47: m = tb1(47) | tb1(42);
      48: m = tb4(48, 47, 21, 20);
      49: m = tb1(49) | tb1(40);
      50: m = tb4(50, 49, 24, 23);
      51: m = tb4(51, 50, 36, 35);
      52: m = tb1(52) | tb1(49);
      53: m = tb4(53, 52, 38, 37);
      54: m = tb4(54, 53, 18, 17);
      55: m = tb1(55) | tb1(31);
      56: m = tb4(56, 55, 35, 34);
      57: m = tb1(57) | tb1(50);
      58: m = tb1(58) | tb1(39);
      59: m = tb4(59, 58, 38, 37);
      60: m = tb1(60) | tb1(59);
      61: m = tb4(61, 60, 46, 45);
      62: m = tb4(62, 61, 6, 5);
      63: m = tb1(63) | tb1(62);
      64: m = tb4(64, 63, 61, 60);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_lane.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_lane
// Purpose  : One XNOR LFSR lane with seed load, single-step advance and
//            lock-up seed replacement (all-ones seed loads all-zeros).
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module lfsr_lane
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 49
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic                i_step,
  input  logic [NUM_BITS-1:0] i_seed,
  output logic [NUM_BITS-1:0] o_state,
  output logic                o_seed_fix
);

  localparam logic [NUM_BITS-1:0] c_tap_mask = NUM_BITS'(lfsr_taps(NUM_BITS));

  logic [NUM_BITS-1:0] r_state;
  logic                r_seed_fix;
  logic                w_seed_ones;
  logic                w_fb;

  // All-ones is the XNOR lock-up state; the feedback is the XNOR of the taps
  assign w_seed_ones = &i_seed;
  assign w_fb        = ~^(r_state & c_tap_mask);

  // Lane register: clear sticky flag on a new start, load seed, or step
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= '0;
      r_seed_fix <= 1'b0;
    end else if (i_clr) begin
      r_seed_fix <= 1'b0;
    end else if (i_load) begin
      r_state    <= w_seed_ones ? '0 : i_seed;
      r_seed_fix <= w_seed_ones;
    end else if (i_step) begin
      r_state    <= {r_state[NUM_BITS-2:0], w_fb};
    end
  end

  assign o_state    = r_state;
  assign o_seed_fix = r_seed_fix;

endmodule
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_gen
// Purpose  : Multi-lane LFSR pattern generator with beat-count and stop-code
//            termination, valid/ready backpressure and abort.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 49,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [NUM_CH*NUM_BITS-1:0] i_seed,
  input  logic [CNT_W-1:0]           i_count,
  input  logic                       i_stop_en,
  input  logic [NUM_BITS-1:0]        i_stop_code,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [NUM_CH*NUM_BITS-1:0] o_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_stop_hit,
  output logic [NUM_CH-1:0]          o_seed_fix
);

  // Reject lane widths the tap table does not cover
  generate
    if (!bits_supported(NUM_BITS)) begin : g_bad_width
      $error("lfsr_gen: NUM_BITS must be in 3..64");
    end
  endgenerate

  state_t                       r_state;
  logic [NUM_CH*NUM_BITS-1:0]   r_seed;
  logic [CNT_W-1:0]             r_count;
  logic [CNT_W-1:0]             r_beat;
  logic                         r_stop_en;
  logic [NUM_BITS-1:0]          r_stop_code;
  logic                         r_valid;
  logic                         r_done;
  logic                         r_stop_hit;

  logic [NUM_CH*NUM_BITS-1:0]   w_data;
  logic [NUM_CH-1:0]            w_seed_fix;
  logic                         w_accept;
  logic                         w_load;
  logic                         w_hs;
  logic                         w_step;
  logic                         w_cnt_last;
  logic                         w_stop_last;
  logic                         w_last;

  // Control decode; r_valid is high exactly while in RUN, so the handshake
  // never depends combinationally on i_ready for o_valid
  assign w_accept    = (r_state == IDLE) && i_start && !i_abort;
  assign w_load      = (r_state == LOAD) && !i_abort;
  assign w_hs        = r_valid && i_ready;
  assign w_step      = w_hs && !i_abort;
  assign w_cnt_last  = (r_count != '0) && (r_beat == (r_count - CNT_W'(1)));
  assign w_stop_last = r_stop_en && (w_data[NUM_BITS-1:0] == r_stop_code);
  assign w_last      = w_cnt_last || w_stop_last;

  // Lane array; each lane k occupies bits [k*NUM_BITS +: NUM_BITS]
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      lfsr_lane #(
        .NUM_BITS (NUM_BITS)
      ) u_lane (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_accept),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_seed     (r_seed[k*NUM_BITS +: NUM_BITS]),
        .o_state    (w_data[k*NUM_BITS +: NUM_BITS]),
        .o_seed_fix (w_seed_fix[k])
      );
    end
  endgenerate

  // Controller: capture on start, count handshaked beats, detect termination
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_seed      <= '0;
      r_count     <= '0;
      r_beat      <= '0;
      r_stop_en   <= 1'b0;
      r_stop_code <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_stop_hit  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_seed      <= i_seed;
            r_count     <= i_count;
            r_stop_en   <= i_stop_en;
            r_stop_code <= i_stop_code;
            r_beat      <= '0;
            r_stop_hit  <= 1'b0;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else begin
            r_valid <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (i_abort) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (w_hs) begin
            // Counter wraps silently in free-run
            r_beat <= r_beat + CNT_W'(1);
            if (w_last) begin
              r_valid    <= 1'b0;
              r_done     <= 1'b1;
              r_stop_hit <= w_stop_last;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = w_data;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_stop_hit = r_stop_hit;
  assign o_seed_fix = w_seed_fix;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_gen
// Purpose  : Directed self-checking bench for lfsr_gen (4-bit and 49-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4-bit single-lane instance
  logic        start4, abort4, stop_en4, ready4;
  logic [3:0]  seed4, stop_code4, data4;
  logic [31:0] count4;
  logic        valid4, busy4, done4, stop_hit4;
  logic [0:0]  seed_fix4;

  // 49-bit four-lane instance
  logic         start49, abort49, stop_en49, ready49;
  logic [195:0] seed49, data49;
  logic [48:0]  stop_code49;
  logic [31:0]  count49;
  logic         valid49, busy49, done49, stop_hit49;
  logic [3:0]   seed_fix49;

  lfsr_gen #(.NUM_BITS(4), .NUM_CH(1), .CNT_W(32)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_abort(abort4),
    .i_seed(seed4), .i_count(count4), .i_stop_en(stop_en4),
    .i_stop_code(stop_code4), .i_ready(ready4), .o_valid(valid4),
    .o_data(data4), .o_busy(busy4), .o_done(done4),
    .o_stop_hit(stop_hit4), .o_seed_fix(seed_fix4)
  );

  lfsr_gen #(.NUM_BITS(49), .NUM_CH(4), .CNT_W(32)) u_dut49 (
    .i_clk(clk), .i_rst(rst), .i_start(start49), .i_abort(abort49),
    .i_seed(seed49), .i_count(count49), .i_stop_en(stop_en49),
    .i_stop_code(stop_code49), .i_ready(ready49), .o_valid(valid49),
    .o_data(data49), .o_busy(busy49), .o_done(done49),
    .o_stop_hit(stop_hit49), .o_seed_fix(seed_fix49)
  );

  int checks   = 0;
  int failures = 0;

  // Hand-computed 4-bit XNOR sequence from 0 (taps at bits 3,2)
  logic [3:0]   seq [0:15];
  logic [195:0] exp49;
  int           beats;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference step for one 49-bit lane: XNOR of bits 48 and 39
  function automatic logic [48:0] step49(input logic [48:0] x);
    return {x[47:0], ~(x[48] ^ x[39])};
  endfunction

  function automatic logic [195:0] step_all(input logic [195:0] x);
    logic [195:0] y;
    y = '0;
    for (int k = 0; k < 4; k++) y[k*49 +: 49] = step49(x[k*49 +: 49]);
    return y;
  endfunction

  initial begin
    seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
    rst = 1'b1;
    start4 = 0; abort4 = 0; stop_en4 = 0; ready4 = 0;
    seed4 = 0; stop_code4 = 0; count4 = 0;
    start49 = 0; abort49 = 0; stop_en49 = 0; ready49 = 0;
    seed49 = '0; stop_code49 = '0; count49 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out4", {valid4, busy4, done4, stop_hit4, seed_fix4, data4}, '0);
    chk("rst_out49", {valid49, busy49, done49, stop_hit49, seed_fix49, data49}, '0);
    rst = 1'b0;
    tick();

    // Count-terminated run of 8 beats from seed 0
    seed4 = 4'h0; count4 = 8; stop_en4 = 0; ready4 = 1; start4 = 1;
    tick();
    start4 = 0;
    chk("t1_busy_load", busy4, 1);
    chk("t1_valid_load", valid4, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_valid_%0d", i), valid4, 1);
      chk($sformatf("t1_data_%0d", i), data4, seq[i]);
      tick();
    end
    chk("t1_valid_fall", valid4, 0);
    chk("t1_done", done4, 1);
    chk("t1_stop_hit", stop_hit4, 0);
    tick();
    chk("t1_done_once", done4, 0);
    chk("t1_idle", busy4, 0);
    chk("t1_next_data", data4, seq[8]);

    // Stop-code termination at 0x7 (inclusive)
    seed4 = 4'h0; count4 = 0; stop_en4 = 1; stop_code4 = 4'h7; start4 = 1;
    tick();
    start4 = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_data_%0d", i), data4, seq[i]);
      tick();
    end
    chk("t2_valid_fall", valid4, 0);
    chk("t2_done", done4, 1);
    chk("t2_stop_hit", stop_hit4, 1);
    tick();
    chk("t2_done_once", done4, 0);
    chk("t2_stop_sticky", stop_hit4, 1);

    // All-ones seed replaced by zero; full period in free-run
    seed4 = 4'hF; count4 = 0; stop_en4 = 0; start4 = 1;
    tick();
    start4 = 0;
    chk("t3_stop_cleared", stop_hit4, 0);
    tick();
    chk("t3_seed_fix", seed_fix4, 1);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t3_data_%0d", i), data4, seq[i]);
      chk($sformatf("t3_no_ones_%0d", i), (data4 != 4'hF), 1);
      tick();
    end
    chk("t3_beat16", data4, 4'h0);
    chk("t3_still_valid", valid4, 1);
    abort4 = 1;
    tick();
    abort4 = 0;
    chk("t3_abort_valid", valid4, 0);
    chk("t3_abort_busy", busy4, 0);
    chk("t3_abort_done", done4, 0);
    chk("t3_fix_retained", seed_fix4, 1);
    tick();
    chk("t3_no_done", done4, 0);

    // Random backpressure, 20 beats
    seed4 = 4'h0; count4 = 20; stop_en4 = 0; ready4 = 1; start4 = 1;
    tick();
    start4 = 0;
    chk("t4_fix_cleared", seed_fix4, 0);
    tick();
    beats = 0;
    for (int cyc = 0; cyc < 400 && valid4; cyc++) begin
      chk($sformatf("t4_data_c%0d", cyc), data4, seq[beats % 15]);
      ready4 = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      if (ready4) beats++;
    end
    chk("t4_beats", beats, 20);
    chk("t4_done", done4, 1);
    chk("t4_stop_hit", stop_hit4, 0);
    ready4 = 1;
    tick();

    // 49-bit, four lanes: lane 2 all-ones, free-run then abort
    seed49 = {49'h0_0000_0000_0001, {49{1'b1}}, 49'h1_0F0F_0F0F_0F0F, 49'h0_1234_5678_9ABC};
    count49 = 0; stop_en49 = 0; ready49 = 1; start49 = 1;
    tick();
    start49 = 0;
    tick();
    exp49 = {49'h0_0000_0000_0001, 49'h0, 49'h1_0F0F_0F0F_0F0F, 49'h0_1234_5678_9ABC};
    chk("t5_seed_fix", seed_fix49, 4'b0100);
    chk("t5_data_0", data49, exp49);
    for (int i = 1; i < 4; i++) begin
      tick();
      exp49 = step_all(exp49);
      chk($sformatf("t5_data_%0d", i), data49, exp49);
    end
    abort49 = 1;
    tick();
    abort49 = 0;
    chk("t5_abort_valid", valid49, 0);
    chk("t5_abort_busy", busy49, 0);
    chk("t5_abort_done", done49, 0);
    chk("t5_fix_retained", seed_fix49, 4'b0100);
    tick();
    chk("t5_no_done", done49, 0);

    // New start with a new count clears sticky flags and runs 3 beats
    seed49 = {49'h1_FFFF_FFFF_FFFE, 49'h0_0000_FFFF_0000, 49'h1_2222_3333_4444, 49'h0_AAAA_5555_0001};
    count49 = 3; start49 = 1;
    tick();
    start49 = 0;
    chk("t5b_fix_cleared", seed_fix49, 4'b0000);
    tick();
    exp49 = seed49;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5b_valid_%0d", i), valid49, 1);
      chk($sformatf("t5b_data_%0d", i), data49, exp49);
      exp49 = step_all(exp49);
      tick();
    end
    chk("t5b_valid_fall", valid49, 0);
    chk("t5b_done", done49, 1);
    chk("t5b_stop_hit", stop_hit49, 0);
    tick();

    // Asynchronous reset in the middle of a run
    seed4 = 4'h0; count4 = 0; stop_en4 = 0; ready4 = 1; start4 = 1;
    tick();
    start4 = 0;
    repeat (4) tick();
    chk("t6_pre_data", data4, seq[3]);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out4", {valid4, busy4, done4, stop_hit4, seed_fix4, data4}, '0);
    chk("t6_rst_out49", {valid49, busy49, done49, stop_hit49, seed_fix49, data49}, '0);
    tick();
    rst = 1'b0;
    tick();

    // Start together with abort in IDLE stays in IDLE
    start4 = 1; abort4 = 1;
    tick();
    start4 = 0; abort4 = 0;
    chk("t6_sa_busy", busy4, 0);
    tick();
    chk("t6_sa_busy2", busy4, 0);
    chk("t6_sa_valid", valid4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
